pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the hold, flush and halt controls of the IF/ID pipeline register, the PC write-hold and the ID/EX bubble insert. It detects load-use and branch-operand hazards, squashes the wrong-path fetch on a taken branch or jump, and drains the pipeline after a halt instruction reaches ID. It sits in the decode stage next to the control unit and the ID-stage branch comparator.

## Interface
Parameters:
- DRAIN_CYCLES, default 3: cycles spent in DRAIN after halt is accepted, so EX/MEM/WB retire; legal range 1-15.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; returns the FSM to RUN immediately
- id_opcode  in  6  opcode field from IF/ID
- id_rs  in  5  rs field from IF/ID
- id_rt  in  5  rt field from IF/ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, bne, sw)
- id_is_branch  in  1  ID instruction is beq/bne (compare done in ID)
- id_branch_taken  in  1  ID comparator result; valid only when id_is_branch
- id_is_jump  in  1  ID instruction is j/jal/jr
- ex_mem_read  in  1  ID/EX instruction is a load
- ex_reg_write  in  1  ID/EX instruction writes a register
- ex_dest  in  5  ID/EX destination register
- mem_mem_read  in  1  EX/MEM instruction is a load
- mem_dest  in  5  EX/MEM destination register
- pc_hold  out  1  1 = PC keeps its value
- ifid_hold  out  1  IF/ID enable input; 0 = load, 1 = hold
- ifid_flush  out  1  IF/ID reset input; 1 = load the nop (opcode 111000)
- ifid_halt  out  1  IF/ID halt input; 1 = regenerate the halt instruction (opcode 101101)
- idex_bubble  out  1  1 = ID/EX latches a nop instead of the decoded control
- halted  out  1  registered; 1 in HALTED
- stall_count  out  16  registered stall-cycle counter (see Configuration)

## Operation
- Define match(r) = (r != 0) && (r == id_rs || (id_uses_rt && r == id_rt)).
- lu_hz = ex_mem_read && match(ex_dest).
- br_hz = id_is_branch && ((ex_reg_write && match(ex_dest)) || (mem_mem_read && match(mem_dest))).
- stall = lu_hz || br_hz.
- FSM states: RUN, DRAIN, HALTED. The 4-bit drain counter is internal.
- RUN, stall=1:
  - pc_hold=1, ifid_hold=1, idex_bubble=1, ifid_flush=0.
  - Branch and jump resolution is suppressed while stalled.
- RUN, stall=0, (id_is_branch && id_branch_taken) || id_is_jump:
  - ifid_flush=1; all other outputs 0.
- RUN, stall=0, id_opcode==6'b101101:
  - pc_hold=1, ifid_halt=1, ifid_hold=0.
  - Transition to DRAIN and load the drain counter with DRAIN_CYCLES-1.
- DRAIN:
  - pc_hold=1, ifid_halt=1, idex_bubble=1.
  - Decrement the counter each cycle. At 0, go to HALTED.
- HALTED:
  - pc_hold=1, ifid_hold=1, idex_bubble=1, halted=1.
  - Stays in HALTED until reset.
- Priority within RUN: stall > halt > flush. A halt in ID behind a load-use waits for the stall to clear.
- Hazard inputs are ignored in DRAIN and HALTED.

## Timing
- All hazard outputs are combinational from the inputs and the registered state. They are sampled by the PC and pipeline registers on the same rising edge.
- Stall lengths:
  - Load-use: 1 cycle.
  - Branch depending on an ALU result in EX: 1 cycle.
  - Branch depending on a load in EX: 2 cycles (lu_hz, then the mem_mem_read term).
- Taken branch or jump: exactly one squashed fetch. Branch penalty is 1 cycle.
- Halt in ID at edge N: DRAIN covers cycles N+1 … N+DRAIN_CYCLES, and halted=1 from edge N+DRAIN_CYCLES+1.
- While reset=1, outputs are forced: pc_hold=1, ifid_flush=1, idex_bubble=1, ifid_hold=0, ifid_halt=0.
- On reset (asynchronous): state=RUN, drain counter=0, halted=0, stall_count=0.
- Reset in mid-DRAIN or in HALTED aborts immediately. The first RUN cycle follows the first edge after deassertion.

## Configuration
- STALL_COUNT_EN defined:
  - stall_count increments on every clk edge with state==RUN && stall==1.
  - It saturates at 16'hFFFF and clears only on reset.
- STALL_COUNT_EN undefined: stall_count is tied to 16'h0000 and no counter flops are built.

## Test plan
- Load-use: lw $2 in EX (ex_mem_read=1, ex_dest=2), add with rs=2 in ID -> exactly one cycle of pc_hold=ifid_hold=idex_bubble=1, then 0. With STALL_COUNT_EN, stall_count=1.
- Dest $0: ex_mem_read=1, ex_dest=0, id_rs=0 -> no stall; all outputs 0.
- Branch after lw: beq rs=5, lw $5 in EX -> stall for 2 cycles. Third cycle with id_branch_taken=1 -> ifid_flush=1 for one cycle.
- Jump: id_is_jump=1 with no hazard -> ifid_flush=1 for one cycle, pc_hold=0.
- Halt: id_opcode=101101 at edge N with DRAIN_CYCLES=3 -> ifid_halt=1 on cycles N…N+3, halted=1 from edge N+4, pc_hold stays 1.
- Reset in DRAIN: assert reset asynchronously mid-drain -> halted=0 and the forced reset outputs appear immediately. After deassertion, a halt re-entry takes the full 3 drain cycles.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - decode-stage hazard, flush and halt-drain controller for the 5-stage pipeline
// Optional stall-cycle counter is built only when STALL_COUNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_is_branch,
    input  logic        id_branch_taken,
    input  logic        id_is_jump,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_dest,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_dest,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        ifid_halt,
    output logic        idex_bubble,
    output logic        halted,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    localparam logic [5:0] OP_HALT    = 6'b101101;
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_drain_cnt;
    logic [3:0] w_drain_cnt_next;
    logic       r_halted;

    logic w_ex_match;
    logic w_mem_match;
    logic w_lu_hz;
    logic w_br_hz;
    logic w_stall;
    logic w_redirect;

    // $0 is hardwired, so a write to it never creates a dependency
    assign w_ex_match  = (ex_dest != 5'd0) &&
                         ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));
    assign w_mem_match = (mem_dest != 5'd0) &&
                         ((mem_dest == id_rs) || (id_uses_rt && (mem_dest == id_rt)));

    assign w_lu_hz    = ex_mem_read && w_ex_match;
    assign w_br_hz    = id_is_branch &&
                        ((ex_reg_write && w_ex_match) || (mem_mem_read && w_mem_match));
    assign w_stall    = w_lu_hz || w_br_hz;
    assign w_redirect = (id_is_branch && id_branch_taken) || id_is_jump;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_drain_cnt <= 4'd0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_drain_cnt_next;
            r_halted    <= (w_next_state == S_HALTED);
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        pc_hold          = 1'b0;
        ifid_hold        = 1'b0;
        ifid_flush       = 1'b0;
        ifid_halt        = 1'b0;
        idex_bubble      = 1'b0;

        case (r_state)
            S_RUN: begin
                if (w_stall) begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                end else if (id_opcode == OP_HALT) begin
                    pc_hold          = 1'b1;
                    ifid_halt        = 1'b1;
                    w_next_state     = S_DRAIN;
                    w_drain_cnt_next = DRAIN_LOAD;
                end else if (w_redirect) begin
                    ifid_flush = 1'b1;
                end
            end
            S_DRAIN: begin
                pc_hold     = 1'b1;
                ifid_halt   = 1'b1;
                idex_bubble = 1'b1;
                if (r_drain_cnt == 4'd0) begin
                    w_next_state = S_HALTED;
                end else begin
                    w_drain_cnt_next = r_drain_cnt - 4'd1;
                end
            end
            S_HALTED: begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idex_bubble = 1'b1;
            end
            default: begin
                w_next_state = S_RUN;
            end
        endcase

        // Reset loads a nop into IF/ID and keeps the PC parked
        if (reset) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b0;
            ifid_flush  = 1'b1;
            ifid_halt   = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    assign halted = r_halted;

`ifdef STALL_COUNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= 16'h0000;
        end else if ((r_state == S_RUN) && w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed plus randomized bench for pipeline_hazard_ctrl against a behavioural model
module tb_pipeline_hazard_ctrl;

    localparam int         DRAIN   = 3;
    localparam logic [5:0] OP_HALT = 6'b101101;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_is_branch;
    logic        id_branch_taken;
    logic        id_is_jump;
    logic        ex_mem_read;
    logic        ex_reg_write;
    logic [4:0]  ex_dest;
    logic        mem_mem_read;
    logic [4:0]  mem_dest;
    logic        pc_hold;
    logic        ifid_hold;
    logic        ifid_flush;
    logic        ifid_halt;
    logic        idex_bubble;
    logic        halted;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    int m_drain_left;
    bit m_halted;
    int m_stalls;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .reset(reset),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken), .id_is_jump(id_is_jump),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_dest(ex_dest),
        .mem_mem_read(mem_mem_read), .mem_dest(mem_dest),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .ifid_halt(ifid_halt),
        .idex_bubble(idex_bubble), .halted(halted), .stall_count(stall_count)
    );

    function automatic bit reads(input logic [4:0] r);
        return (r != 5'd0) && ((r == id_rs) || (id_uses_rt && (r == id_rt)));
    endfunction

    function automatic bit model_stall();
        bit load_use;
        bit branch_dep;
        load_use   = ex_mem_read && reads(ex_dest);
        branch_dep = id_is_branch && ((ex_reg_write && reads(ex_dest)) ||
                                      (mem_mem_read && reads(mem_dest)));
        return load_use || branch_dep;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_drain_left = 0;
        m_halted     = 1'b0;
        m_stalls     = 0;
    endtask

    task automatic check_outputs(input string tag);
        bit e_pc, e_hold, e_flush, e_halt, e_bub;
        logic [15:0] e_cnt;
        {e_pc, e_hold, e_flush, e_halt, e_bub} = 5'b0;
        if (reset) begin
            {e_pc, e_flush, e_bub} = 3'b111;
        end else if (m_halted) begin
            {e_pc, e_hold, e_bub} = 3'b111;
        end else if (m_drain_left > 0) begin
            {e_pc, e_halt, e_bub} = 3'b111;
        end else if (model_stall()) begin
            {e_pc, e_hold, e_bub} = 3'b111;
        end else if (id_opcode == OP_HALT) begin
            {e_pc, e_halt} = 2'b11;
        end else if ((id_is_branch && id_branch_taken) || id_is_jump) begin
            e_flush = 1'b1;
        end
`ifdef STALL_COUNT_EN
        e_cnt = 16'(m_stalls);
`else
        e_cnt = 16'h0000;
`endif
        chk({tag, ".pc_hold"},     16'(pc_hold),     16'(e_pc));
        chk({tag, ".ifid_hold"},   16'(ifid_hold),   16'(e_hold));
        chk({tag, ".ifid_flush"},  16'(ifid_flush),  16'(e_flush));
        chk({tag, ".ifid_halt"},   16'(ifid_halt),   16'(e_halt));
        chk({tag, ".idex_bubble"}, 16'(idex_bubble), 16'(e_bub));
        chk({tag, ".halted"},      16'(halted),      16'(m_halted));
        chk({tag, ".stall_count"}, stall_count,      e_cnt);
    endtask

    task automatic idle();
        id_opcode = 6'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        id_is_branch = 1'b0; id_branch_taken = 1'b0; id_is_jump = 1'b0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dest = 5'd0;
        mem_mem_read = 1'b0; mem_dest = 5'd0;
    endtask

    task automatic randomize_inputs(input bit allow_halt);
        id_opcode       = 6'($urandom_range(0, 63));
        if (!allow_halt && id_opcode == OP_HALT) id_opcode = 6'd0;
        id_rs           = 5'($urandom_range(0, 3));
        id_rt           = 5'($urandom_range(0, 3));
        id_uses_rt      = 1'($urandom_range(0, 1));
        id_is_branch    = 1'($urandom_range(0, 1));
        id_branch_taken = 1'($urandom_range(0, 1));
        id_is_jump      = 1'($urandom_range(0, 1));
        ex_mem_read     = 1'($urandom_range(0, 1));
        ex_reg_write    = 1'($urandom_range(0, 1));
        ex_dest         = 5'($urandom_range(0, 3));
        mem_mem_read    = 1'($urandom_range(0, 1));
        mem_dest        = 5'($urandom_range(0, 3));
    endtask

    // Called 1 time unit after a rising edge with inputs already applied
    task automatic step(input string tag);
        #3;
        check_outputs(tag);
        if (!m_halted) begin
            if (m_drain_left > 0) begin
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1'b1;
            end else if (model_stall()) begin
                if (m_stalls < 65535) m_stalls++;
            end else if (id_opcode == OP_HALT) begin
                m_drain_left = DRAIN;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("reset");
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;

        idle(); step("idle");
        idle(); ex_mem_read = 1'b1; ex_dest = 5'd2; id_rs = 5'd2; step("lu_stall");
        idle(); step("lu_clear");
        idle(); ex_mem_read = 1'b1; step("dest0");
        idle(); ex_mem_read = 1'b1; ex_dest = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; step("lu_rt");

        idle(); id_is_branch = 1'b1; id_rs = 5'd5; id_branch_taken = 1'b1;
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd5; step("br_lw1");
        idle(); id_is_branch = 1'b1; id_rs = 5'd5; id_branch_taken = 1'b1;
        mem_mem_read = 1'b1; mem_dest = 5'd5; step("br_lw2");
        idle(); id_is_branch = 1'b1; id_rs = 5'd5; id_branch_taken = 1'b1; step("br_taken");
        idle(); step("after_br");

        idle(); id_is_branch = 1'b1; id_rs = 5'd4; ex_reg_write = 1'b1; ex_dest = 5'd4; step("br_alu");
        idle(); id_is_branch = 1'b1; id_rs = 5'd4; step("br_not_taken");
        idle(); id_is_jump = 1'b1; step("jump");
        idle(); step("after_jump");

        for (int i = 0; i < 300; i++) begin
            randomize_inputs(1'b0);
            step("rand");
        end

        idle(); id_opcode = OP_HALT; ex_mem_read = 1'b1; ex_dest = 5'd1; id_rs = 5'd1; step("halt_stalled");
        idle(); id_opcode = OP_HALT; id_is_jump = 1'b1; step("halt_accept");
        for (int i = 0; i < DRAIN; i++) begin
            randomize_inputs(1'b1);
            step("drain");
        end
        for (int i = 0; i < 3; i++) begin
            randomize_inputs(1'b1);
            step("halted");
        end

        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("reset_in_halted");
        reset = 1'b0;
        @(posedge clk);
        #1;

        idle(); id_opcode = OP_HALT; step("halt2_accept");
        idle(); step("drain2");
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("reset_in_drain");
        reset = 1'b0;
        @(posedge clk);
        #1;

        idle(); step("run_after_reset");
        idle(); id_opcode = OP_HALT; step("halt3_accept");
        for (int i = 0; i < DRAIN + 2; i++) begin
            randomize_inputs(1'b1);
            step("halt3_seq");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
